// File: rtl/seq_scan_ctrl.sv
// Serial scan controller: shifts each accepted word MSB-first into an external pattern
// detector and counts the detector's match flags into a saturating per-word result.
module seq_scan_ctrl #(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_clr,
    output logic          ser_en,
    output logic          ser_bit,
    output logic          det_rst_n,
    input  logic          det_flag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_hit,
    output logic          busy
);

    localparam int unsigned IW = (W > 2) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IdxLast = IW'(W - 1);
    localparam logic [CW-1:0] CntMax  = '1;

    typedef enum logic [2:0] {StIdle, StClr, StShift, StDrain, StReport} state_e;

    state_e        state_q;
    logic [W-1:0]  sreg_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sreg_q  <= in_data;
                        idx_q   <= '0;
                        count_q <= '0;
                        state_q <= in_clr ? StClr : StShift;
                    end
                end
                StClr: state_q <= StShift;
                StShift: begin
                    sreg_q <= {sreg_q[W-2:0], 1'b0};
                    idx_q  <= idx_q + 1'b1;
                    // The flag seen on the first bit belongs to the previous word's history.
                    if (idx_q != '0 && det_flag && count_q != CntMax) begin
                        count_q <= count_q + 1'b1;
                    end
                    if (idx_q == IdxLast) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (det_flag && count_q != CntMax) begin
                        count_q <= count_q + 1'b1;
                    end
                    state_q <= StReport;
                end
                StReport: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode the registered state; rst_n forces the reset values while held low.
    assign in_ready  = rst_n && (state_q == StIdle);
    assign busy      = rst_n && (state_q != StIdle);
    assign ser_en    = rst_n && (state_q == StShift);
    assign ser_bit   = ser_en && sreg_q[W-1];
    assign det_rst_n = rst_n && (state_q != StClr);
    assign out_valid = rst_n && (state_q == StReport);
    assign out_count = rst_n ? count_q : '0;
    assign out_hit   = |out_count;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl with forced-flag modes and a behavioural 1101 detector.
module tb_seq_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_clr, out_ready;
    logic [15:0] in_data;
    logic        in_ready, ser_en, ser_bit, det_rst_n, det_flag, out_valid, out_hit, busy;
    logic [4:0]  out_count;
    logic        in_ready3, ser_en3, ser_bit3, det_rst_n3, out_valid3, out_hit3, busy3;
    logic [2:0]  out_count3;

    int checks = 0;
    int errors = 0;
    int lat;
    int ir_cnt;
    int mode;   // 0: flag held 0, 1: flag held 1, 2: behavioural 1101 detector
    logic [3:0]  hist;
    logic        flag;
    logic [15:0] pat;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.W(16), .CW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_clr(in_clr), .ser_en(ser_en), .ser_bit(ser_bit),
        .det_rst_n(det_rst_n), .det_flag(det_flag), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .out_hit(out_hit), .busy(busy)
    );

    seq_scan_ctrl #(.W(16), .CW(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .in_clr(in_clr), .ser_en(ser_en3), .ser_bit(ser_bit3),
        .det_rst_n(det_rst_n3), .det_flag(det_flag), .out_valid(out_valid3),
        .out_ready(out_ready), .out_count(out_count3), .out_hit(out_hit3), .busy(busy3)
    );

    always @(posedge clk) begin
        if (!det_rst_n) begin
            hist <= 4'b0;
            flag <= 1'b0;
        end else if (ser_en) begin
            hist <= {hist[2:0], ser_bit};
            flag <= ({hist[2:0], ser_bit} == 4'b1101);
        end
    end

    assign det_flag = (mode == 1) ? 1'b1 : (mode == 2) ? flag : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [15:0] data, input logic clr);
        in_valid = 1'b1;
        in_data  = data;
        in_clr   = clr;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_clr = 1'b0; out_ready = 1'b1;
        in_data = '0; mode = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_det_rst_n", det_rst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ser", {ser_en, ser_bit, out_valid}, 0);
        chk("rst_count", {out_count, out_hit}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);

        // 0xA5C3 with clear, flag held 0; in_valid/in_data wiggle while busy
        pat = 16'hA5C3;
        offer(16'hA5C3, 1'b1);
        chk("clr_det_rst_n", det_rst_n, 0);
        chk("clr_ser_en", ser_en, 0);
        chk("clr_busy", {busy, in_ready}, 2'b10);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("shift%0d_bit", i), {ser_en, ser_bit, det_rst_n},
                {1'b1, pat[15-i], 1'b1});
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain", {ser_en, out_valid, det_rst_n}, 3'b001);
        @(negedge clk);
        chk("a5c3_valid", out_valid, 1);
        chk("a5c3_count", {out_count, out_hit}, 0);
        @(negedge clk);
        chk("a5c3_idle", {in_ready, out_valid, ser_en, ser_bit}, 4'b1000);

        // flag forced 1, consumer stalls 5 cycles in REPORT
        mode = 1;
        out_ready = 1'b0;
        offer(16'h1234, 1'b0);
        wait_result(lat);
        chk("lat_noclr", lat, 17);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {out_valid, in_ready}, 2'b10);
            chk("stall_count", {out_count, out_hit}, {5'd16, 1'b1});
            chk("stall_count_cw3", {out_count3, out_hit3}, {3'd7, 1'b1});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", {in_ready, out_valid, busy}, 3'b100);
        mode = 0;

        // reset in SHIFT cycle 8
        offer(16'hF0F0, 1'b0);
        repeat (7) @(negedge clk);
        chk("mid_shift", ser_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort", {busy, ser_en, out_valid, in_ready, det_rst_n}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", {in_ready, out_valid}, 2'b10);

        // behavioural detector, cleared history: 0000_1101_1101_1101 has 3 matches
        mode = 2;
        offer(16'h0DDD, 1'b1);
        wait_result(lat);
        chk("lat_clr", lat, 18);
        chk("dddd_count", {out_count, out_hit}, {5'd3, 1'b1});

        // back-to-back 0x000D then 0x0000 without clear
        @(negedge clk);
        offer(16'h000D, 1'b0);
        wait_result(lat);
        chk("w000d_count", {out_count, out_hit}, {5'd1, 1'b1});
        in_valid = 1'b1;
        in_data  = 16'h0000;
        in_clr   = 1'b0;
        ir_cnt   = 0;
        @(negedge clk);
        if (in_ready) ir_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        if (in_ready) ir_cnt++;
        chk("in_ready_once", ir_cnt, 1);
        chk("b2b_busy", busy, 1);
        wait_result(lat);
        chk("b2b_lat", lat, 17);
        chk("w0000_count", {out_count, out_hit}, {5'd0, 1'b0});

        // match spanning the boundary: ...0001 | 1010... counted in the later word
        @(negedge clk);
        offer(16'h0001, 1'b0);
        wait_result(lat);
        chk("w0001_count", out_count, 0);
        @(negedge clk);
        offer(16'hA000, 1'b0);
        wait_result(lat);
        chk("wa000_count", {out_count, out_hit}, {5'd1, 1'b1});
        @(negedge clk);
        chk("final_idle", {in_ready, busy}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
